// File: rtl/grf_pkg.sv
// Shared constants and helpers for the multi-port general-purpose register file.
package grf_pkg;

    localparam int GRF_DW   = 32;
    localparam int GRF_AW   = 5;
    localparam int ZERO_REG = 0;

    // LSB position of packed port i in a bus of equal-width fields.
    function automatic int port_lsb(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/grf_rd_mux.sv
// One read port: zero-register check, write-port bypass (port 1 first), array select.
module grf_rd_mux
    import grf_pkg::*;
#(
    parameter int DW     = GRF_DW,
    parameter int AW     = GRF_AW,
    parameter int BYPASS = 1
) (
    input  logic          reset_i,
    input  logic [AW-1:0] ra_i,
    input  logic          we0_i,
    input  logic [AW-1:0] wa0_i,
    input  logic [DW-1:0] wd0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] wa1_i,
    input  logic [DW-1:0] wd1_i,
    input  logic [DW-1:0] mem_i [2**AW],
    output logic [DW-1:0] rd_o
);

    logic hit0;
    logic hit1;
    logic fwd_ok;

    assign hit0   = we0_i && (wa0_i == ra_i);
    assign hit1   = we1_i && (wa1_i == ra_i);
    // A write presented during reset is dropped, so it must never be forwarded.
    assign fwd_ok = (BYPASS != 0) && !reset_i;

    // Select the read data: register 0 is always zero, then bypass, then storage.
    always_comb begin
        rd_o = mem_i[ra_i];
        if (ra_i == AW'(ZERO_REG)) begin
            rd_o = '0;
        end else if (fwd_ok && hit1) begin
            rd_o = wd1_i;
        end else if (fwd_ok && hit0) begin
            rd_o = wd0_i;
        end
    end

endmodule

// File: rtl/grf_mp.sv
// Parametrised register file: two prioritised write ports, NUM_RD combinational
// read ports with optional same-cycle bypass, and a per-register written bitmap.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW     = GRF_DW,
    parameter int AW     = GRF_AW,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD*DW-1:0] rd,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [DW-1:0]        wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [DW-1:0]        wd1,
    output logic [2**AW-1:0]     written
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic             commit0;
    logic             commit1;

    assign commit0 = we0 && (wa0 != AW'(ZERO_REG));
    assign commit1 = we1 && (wa1 != AW'(ZERO_REG));

    // Commit writes; port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            written_q <= '0;
        end else begin
            if (commit0) begin
                mem_q[wa0]     <= wd0;
                written_q[wa0] <= 1'b1;
            end
            if (commit1) begin
                mem_q[wa1]     <= wd1;
                written_q[wa1] <= 1'b1;
            end
        end
    end

    assign written = written_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        grf_rd_mux #(
            .DW     (DW),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rd_mux (
            .reset_i (reset),
            .ra_i    (ra[port_lsb(i, AW) +: AW]),
            .we0_i   (we0),
            .wa0_i   (wa0),
            .wd0_i   (wd0),
            .we1_i   (we1),
            .wa1_i   (wa1),
            .wd1_i   (wd1),
            .mem_i   (mem_q),
            .rd_o    (rd[port_lsb(i, DW) +: DW])
        );
    end

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: a bypass build and a non-bypass build driven in parallel,
// checked against a behavioural register-file model.
module tb_grf_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ra;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [63:0] rd_b, rd_n;
    logic [31:0] wr_b, wr_n;

    logic [31:0] m [32];
    logic [31:0] wmap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    grf_mp #(.DW(32), .AW(5), .NUM_RD(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .written(wr_b)
    );

    grf_mp #(.DW(32), .AW(5), .NUM_RD(2), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .written(wr_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && !reset) begin
            if (we1 && wa1 == a) return wd1;
            if (we0 && wa0 == a) return wd0;
        end
        return m[a];
    endfunction

    task automatic model_commit();
        if (reset) begin
            for (int k = 0; k < 32; k++) m[k] = 32'h0;
            wmap = 32'h0;
        end else begin
            if (we0 && wa0 != 5'd0) begin m[wa0] = wd0; wmap[wa0] = 1'b1; end
            if (we1 && wa1 != 5'd0) begin m[wa1] = wd1; wmap[wa1] = 1'b1; end
        end
    endtask

    // Drive one cycle, check combinational reads and the bitmap, then commit at the edge.
    task automatic step(input logic rst,
                        input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1);
        reset = rst;
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        ra  = {r1, r0};
        #1;
        check("byp_rd0", rd_b[31:0],  exp_rd(r0, 1'b1));
        check("byp_rd1", rd_b[63:32], exp_rd(r1, 1'b1));
        check("nob_rd0", rd_n[31:0],  exp_rd(r0, 1'b0));
        check("nob_rd1", rd_n[63:32], exp_rd(r1, 1'b0));
        check("byp_written", wr_b, wmap);
        check("nob_written", wr_n, wmap);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    initial begin
        logic       rst, e0, e1;
        logic [4:0] a0, a1, r0, r1;

        for (int k = 0; k < 32; k++) m[k] = 32'h0;
        wmap = 32'h0;

        // Initial reset; reads before it are undefined and are not checked.
        reset = 1'b1; we0 = 1'b0; we1 = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
        @(posedge clk);
        @(negedge clk);

        // Every address reads zero after reset, on both ports.
        for (int a = 0; a < 32; a += 2)
            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1));
        check("reset_written", wr_b, 32'h0);

        // Port 0 write with same-cycle read, then held value and bitmap.
        step(1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; ra = {5'd5, 5'd5}; #1;
        check("hold5", rd_b[31:0], 32'h12345678);
        check("written5", {31'h0, wr_b[5]}, 32'h1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);

        // Collision on 7: port 1 wins; then parallel writes to 3 and 4.
        step(1'b0, 1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h5555FFFF, 5'd7, 5'd7);
        check("coll7_stored", rd_n[31:0], 32'h5555FFFF);
        step(1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444, 5'd3, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);

        // Writes to register 0 are discarded, including bypass.
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        check("written0", {31'h0, wr_b[0]}, 32'h0);

        // Non-bypass visibility: old value in write cycle, new value after.
        step(1'b0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

        // Write during reset is dropped and not forwarded; a later write lands.
        step(1'b1, 1'b1, 5'd10, 32'h1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
        step(1'b0, 1'b1, 5'd10, 32'h2, 1'b0, 5'd0, 32'h0, 5'd10, 5'd5);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
        check("reg10", rd_n[31:0], 32'h2);

        // Randomised traffic with forced collisions and occasional resets.
        for (int it = 0; it < 400; it++) begin
            rst = ($urandom_range(0, 39) == 0);
            e0  = 1'($urandom_range(0, 1));
            e1  = 1'($urandom_range(0, 1));
            a0  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1  = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
            case ($urandom_range(0, 2))
                0:       r0 = a0;
                1:       r0 = a1;
                default: r0 = 5'($urandom);
            endcase
            r1  = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom);
            step(rst, e0, a0, $urandom, e1, a1, $urandom, r0, r1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general-purpose register file; next generation of the single-write, dual-read GRF.
- Adds configurable data width, depth and read-port count, plus a second write port with fixed priority.
- Adds optional same-cycle write-to-read bypass and a per-register "written" bitmap.
- Sits in the CPU decode/writeback stage. Reads feed operand selection; write ports take the writeback (W) result and a secondary writer (e.g. a second commit lane).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a read of an address being written this cycle returns the new data; 0 = reads return stored value only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; clears all registers and the written bitmap.
- ra  input  NUM_RD*AW  packed read addresses; port i at bits [i*AW +: AW].
- rd  output  NUM_RD*DW  packed read data; port i at bits [i*DW +: DW].
- we0  input  1  write enable, port 0.
- wa0  input  AW  write address, port 0.
- wd0  input  DW  write data, port 0.
- we1  input  1  write enable, port 1 (higher priority).
- wa1  input  AW  write address, port 1.
- wd1  input  DW  write data, port 1.
- written  output  2**AW  bit k = 1 once register k has been committed since the last reset.

Behaviour:
- Storage: 2**AW x DW flops. Register 0 is hardwired to 0; writes to address 0 are discarded and written[0] stays 0.
- Commit: at posedge clk with reset=0:
  - weN=1 and waN!=0 -> reg[waN] <= wdN and written[waN] <= 1.
  - Both ports enabled with wa0==wa1 -> port 1 wins; reg gets wd1.
  - Different addresses -> both commit in the same cycle.
- Reset: at posedge clk with reset=1, all registers <= 0 and written <= 0.
  - Writes presented in a reset cycle are dropped.
  - No asynchronous effect; a reset asserted mid-stream takes effect only at the next edge.
  - After the reset edge every rd port reads 0 (with BYPASS=1, only if no write to that address is currently presented).
- Read: combinational, zero cycle latency.
  - ra_i==0 -> rd_i = 0, always, including with bypass.
  - BYPASS=1, reset=0, ra_i!=0: if we1 and wa1==ra_i -> rd_i = wd1; else if we0 and wa0==ra_i -> rd_i = wd0; else rd_i = reg[ra_i].
  - BYPASS=1, reset=1: bypass is suppressed; rd_i = reg[ra_i]. The write will be dropped, so it must not be forwarded.
  - BYPASS=0: rd_i = reg[ra_i]; a new value is visible the cycle after commit.
- Any number of read ports may read the same address simultaneously.
- written is a registered output; it is all-zero out of reset.
- No X propagation: all storage is initialised by reset. Reads before the first reset are undefined and are not checked.

Decomposition:
- Shared package grf_pkg holds:
  - default constants GRF_DW=32, GRF_AW=5;
  - localparam ZERO_REG = 0;
  - a function to slice packed port i.
- One natural sub-module: grf_rd_mux. It implements one read port's zero check, priority bypass and array select, and is instantiated NUM_RD times in a generate loop.
- Write/commit logic and the bitmap stay in grf_mp.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rd = 0x00000000, written = 0.
- we0=1, wa0=5, wd0=0x12345678, ra port0=5, BYPASS=1 -> rd0 = 0x12345678 in the same cycle. Next cycle with we0=0 -> still 0x12345678, written[5]=1.
- we0 and we1 both to addr 7, wd0=0xAAAA0000, wd1=0x5555FFFF -> bypass and stored value are 0x5555FFFF. Simultaneous wa0=3 and wa1=4 -> both commit.
- we1=1, wa1=0, wd1=0xFFFFFFFF -> rd for ra=0 stays 0 in both the write cycle and the next; written[0]=0.
- BYPASS=0 build: write 0xDEADBEEF to reg 9 while reading 9 -> old value (0) in the write cycle, 0xDEADBEEF the next cycle.
- Write reg 10 = 0x1 while reset=1 -> rd (ra=10) = 0 during that cycle with no bypass, and 0 after the edge; written[10]=0. Then write reg 10 = 0x2 with reset=0 -> reg 10 = 0x2 after the edge.
